// File: rtl/io_sim_if.sv
// io_sim_if: processor memory bus (AS_N/WR_N/ACK_N handshake, address and data lines).
interface io_sim_if;
  logic        AS_N;
  logic        WR_N;
  logic [31:0] MAO;
  logic [31:0] MDO;
  logic        ACK_N;
  logic [31:0] DO;
  modport master (output AS_N, WR_N, MAO, MDO, input ACK_N, DO);
  modport slave  (input AS_N, WR_N, MAO, MDO, output ACK_N, DO);
endinterface

// File: rtl/io_sim.sv
// io_sim: DLX simulation I/O: clock pass-through, reset sync, step pulse, bus memory slave.
// IO_SIM_WRITE_EN enables memory writes; otherwise memory is read-only.
module io_sim #(
  parameter int AW = 10
) (
  input  logic CLK_IN,
  input  logic RST_IN,
  input  logic STEP_IN,
  output logic CLK,
  output logic RST,
  output logic STEP,
  io_sim_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  state_t state_q, state_d;
  logic [1:0] rst_q;
  logic step1_q, step2_q;
  logic [31:0] do_q, do_d;
  logic [AW-1:0] idx;
  logic take;
  logic unused;
  logic [31:0] mem [2**AW];
  assign CLK = CLK_IN;
  assign RST = rst_q[1];
  assign STEP = step1_q & ~step2_q;
  assign idx = bus.MAO[AW+1:2];
  assign take = state_q == WAIT && !bus.AS_N;
  assign bus.ACK_N = state_q != ACK;
  assign bus.DO = do_q;
`ifdef IO_SIM_WRITE_EN
  logic we;
  assign we = take && !bus.WR_N;
  assign unused = ^{bus.MAO[31:AW+2], bus.MAO[1:0]};
  always_comb begin
    state_d = bus.AS_N ? IDLE : state_q == IDLE ? WAIT : ACK;
    do_d = take ? (bus.WR_N ? mem[idx] : bus.MDO) : do_q;
  end
`else
  assign unused = ^{bus.MAO[31:AW+2], bus.MAO[1:0], bus.WR_N, bus.MDO};
  always_comb begin
    state_d = bus.AS_N ? IDLE : state_q == IDLE ? WAIT : ACK;
    do_d = take ? mem[idx] : do_q;
  end
`endif
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      state_q <= IDLE;
      rst_q <= 2'b11;
      step1_q <= 1'b0;
      step2_q <= 1'b0;
      do_q <= '0;
    end else begin
      state_q <= state_d;
      rst_q <= {rst_q[0], 1'b0};
      step1_q <= STEP_IN;
      step2_q <= step1_q;
      do_q <= do_d;
    end
  end
  // Power-up contents word i = i live in the declaration initialisers; reset never touches them.
  for (genvar i = 0; i < 2**AW; i++) begin : g_w
`ifdef IO_SIM_WRITE_EN
    logic [31:0] w_q = 32'(i);
    always_ff @(posedge CLK_IN)
      if (we && idx == AW'(i)) w_q <= bus.MDO;
    assign mem[i] = w_q;
`else
    assign mem[i] = 32'(i);
`endif
  end
endmodule

// File: tb/tb_io_sim.sv
// tb_io_sim: directed self-checking bench for io_sim (reset, step, read, write, abort, alias, reset mid-ACK).
module tb_io_sim;
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic step_in = 1'b0;
  logic clk, rst, step;
  int errors = 0;
  int checks = 0;
  int pulses;
  io_sim_if bus ();
  io_sim #(.AW(10)) dut (
    .CLK_IN(clk_in), .RST_IN(rst_in), .STEP_IN(step_in),
    .CLK(clk), .RST(rst), .STEP(step), .bus(bus)
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk_in);
  endtask
  task automatic txn(input string tag, input logic [31:0] a, input logic [31:0] d,
                     input logic w, input logic [31:0] exp);
    bus.MAO = a;
    bus.MDO = d;
    bus.WR_N = w;
    bus.AS_N = 1'b0;
    cyc();
    chk({tag, "_wait_ack_n"}, 32'(bus.ACK_N), 1);
    cyc();
    chk({tag, "_ack_n"}, 32'(bus.ACK_N), 0);
    chk({tag, "_do"}, bus.DO, exp);
    cyc();
    cyc();
    chk({tag, "_ack_hold"}, 32'(bus.ACK_N), 0);
    bus.AS_N = 1'b1;
    bus.WR_N = 1'b1;
    cyc();
    chk({tag, "_ack_rel"}, 32'(bus.ACK_N), 1);
    chk({tag, "_do_hold"}, bus.DO, exp);
  endtask
  logic [31:0] w1, wc;
  initial begin
`ifdef IO_SIM_WRITE_EN
    w1 = 32'h12345678;
    wc = 32'h0000cafe;
`else
    w1 = 32'h00000001;
    wc = 32'h00000003;
`endif
    bus.AS_N = 1'b1;
    bus.WR_N = 1'b1;
    bus.MAO = '0;
    bus.MDO = '0;
    #1 rst_in = 1'b1;
    #1;
    chk("rst_async", 32'(rst), 1);
    chk("rst_ack_n", 32'(bus.ACK_N), 1);
    chk("rst_step", 32'(step), 0);
    chk("rst_do", bus.DO, 0);
    cyc();
    chk("clk_follow_lo", 32'(clk), 32'(clk_in));
    #5;
    chk("clk_follow_hi", 32'(clk), 32'(clk_in));
    cyc();
    rst_in = 1'b0;
    cyc();
    chk("rst_edge1", 32'(rst), 1);
    cyc();
    chk("rst_edge2", 32'(rst), 0);
    // single-cycle step request
    step_in = 1'b1;
    cyc();
    chk("step1_hi", 32'(step), 1);
    step_in = 1'b0;
    cyc();
    chk("step1_lo", 32'(step), 0);
    cyc();
    // five-cycle step request must still give one pulse
    pulses = 0;
    step_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      pulses += int'(step);
      if (i == 1) chk("step5_second", 32'(step), 0);
    end
    step_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      pulses += int'(step);
    end
    chk("step5_pulses", 32'(pulses), 1);
    txn("rd4", 32'h4, 32'h0, 1'b1, 32'h1);
    txn("wr4", 32'h4, 32'h12345678, 1'b0, w1);
    txn("rd4b", 32'h4, 32'h0, 1'b1, w1);
    // abort: AS_N low for one cycle only
    bus.MAO = 32'h8;
    bus.MDO = 32'hdeadbeef;
    bus.WR_N = 1'b0;
    bus.AS_N = 1'b0;
    cyc();
    bus.AS_N = 1'b1;
    bus.WR_N = 1'b1;
    cyc();
    chk("abort_ack_n", 32'(bus.ACK_N), 1);
    chk("abort_do", bus.DO, w1);
    cyc();
    chk("abort_ack_n2", 32'(bus.ACK_N), 1);
    txn("rd8", 32'h8, 32'h0, 1'b1, 32'h2);
    txn("alias", 32'h1004, 32'h0, 1'b1, w1);
    txn("rd3ff", 32'hffc, 32'h0, 1'b1, 32'h3ff);
    // reset while in ACK after a completed write
    bus.MAO = 32'hc;
    bus.MDO = 32'h0000cafe;
    bus.WR_N = 1'b0;
    bus.AS_N = 1'b0;
    cyc();
    cyc();
    chk("mid_ack_n", 32'(bus.ACK_N), 0);
    #2 rst_in = 1'b1;
    #1;
    chk("mid_rst_ack_n", 32'(bus.ACK_N), 1);
    chk("mid_rst_rst", 32'(rst), 1);
    bus.AS_N = 1'b1;
    bus.WR_N = 1'b1;
    cyc();
    rst_in = 1'b0;
    cyc();
    cyc();
    chk("mid_rel_ack_n", 32'(bus.ACK_N), 1);
    chk("mid_rel_do", bus.DO, 0);
    txn("rdc", 32'hc, 32'h0, 1'b1, wc);
    // reset while in WAIT drops the pending write
    bus.MAO = 32'h10;
    bus.MDO = 32'h55aa55aa;
    bus.WR_N = 1'b0;
    bus.AS_N = 1'b0;
    cyc();
    rst_in = 1'b1;
    cyc();
    bus.AS_N = 1'b1;
    bus.WR_N = 1'b1;
    rst_in = 1'b0;
    cyc();
    cyc();
    txn("rd10", 32'h10, 32'h0, 1'b1, 32'h4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
